tm_clause_engine: RTL

- Time-multiplexed Tsetlin-machine inference engine. Evaluates every clause of every class against one feature vector, one clause per cycle.
- Accumulates polarity-weighted class sums and produces an argmax class prediction.
- Supersedes single-clause combinational evaluation. Sits between the feature binariser and the classifier output stage.
- Clause exclude masks are held in an internal register bank and loaded through a config write port.

---
 rtl/tm_pkg.sv | 28 ++
 rtl/tm_clause_eval.sv | 23 ++
 rtl/tm_clause_engine.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tm_pkg.sv
// Shared constants, width helpers and FSM state type for the Tsetlin-machine clause engine.
package tm_pkg;

  localparam int DEF_NUM_FEATURES = 9;
  localparam int DEF_NUM_CLAUSES  = 12;
  localparam int DEF_NUM_CLASSES  = 3;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sum_w(input int num_clauses);
    return $clog2(num_clauses) + 2;
  endfunction

  localparam int LIT_W  = 2 * DEF_NUM_FEATURES;
  localparam int SUM_W  = sum_w(DEF_NUM_CLAUSES);
  localparam int ADDR_W = idx_w(DEF_NUM_CLASSES * DEF_NUM_CLAUSES);
  localparam int CLS_W  = idx_w(DEF_NUM_CLASSES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } tm_state_e;

endpackage

// File: rtl/tm_clause_eval.sv
// Single Tsetlin clause: AND of the non-excluded literals of {features, ~features}.
module tm_clause_eval
  import tm_pkg::*;
#(
  parameter int NUM_FEATURES     = DEF_NUM_FEATURES,
  parameter bit EMPTY_CLAUSE_OUT = 1'b0
) (
  input  logic [NUM_FEATURES-1:0]   features,
  input  logic [2*NUM_FEATURES-1:0] exclude,
  output logic                      clause
);

  logic [2*NUM_FEATURES-1:0] lits;

  assign lits = {features, ~features};

  // A fully excluded clause has no literals; its value is a convention, not an AND.
  always_comb begin
    if (&exclude) clause = EMPTY_CLAUSE_OUT;
    else          clause = &(lits | exclude);
  end

endmodule

// File: rtl/tm_clause_engine.sv
// Time-multiplexed Tsetlin-machine inference: one clause per cycle, signed class sums, argmax.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid holds until then.
module tm_clause_engine
  import tm_pkg::*;
#(
  parameter int NUM_FEATURES     = DEF_NUM_FEATURES,
  parameter int NUM_CLAUSES      = DEF_NUM_CLAUSES,
  parameter int NUM_CLASSES      = DEF_NUM_CLASSES,
  parameter bit EMPTY_CLAUSE_OUT = 1'b0
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               cfg_we,
  input  logic [idx_w(NUM_CLASSES*NUM_CLAUSES)-1:0]          cfg_addr,
  input  logic [2*NUM_FEATURES-1:0]                          cfg_data,
  output logic                                               busy,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [NUM_FEATURES-1:0]                            features,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [NUM_CLASSES*sum_w(NUM_CLAUSES)-1:0]          class_sums,
  output logic [idx_w(NUM_CLASSES)-1:0]                      pred_class,
  output tm_state_e                                          dbg_state
);

  localparam int NLIT  = 2 * NUM_FEATURES;
  localparam int TOTAL = NUM_CLASSES * NUM_CLAUSES;
  localparam int AW    = idx_w(TOTAL);
  localparam int SW    = sum_w(NUM_CLAUSES);
  localparam int CW    = idx_w(NUM_CLASSES);
  localparam int JW    = idx_w(NUM_CLAUSES);

  localparam logic [AW:0]   TOTAL_L  = (AW+1)'(TOTAL);
  localparam logic [JW-1:0] LAST_J   = JW'(NUM_CLAUSES - 1);
  localparam logic [CW-1:0] LAST_CLS = CW'(NUM_CLASSES - 1);

  tm_state_e state, state_nxt;

  logic [NLIT-1:0]         masks [TOTAL];
  logic [NUM_FEATURES-1:0] feat_q;
  logic [AW-1:0]           idx_q;
  logic [CW-1:0]           cls_q;
  logic [JW-1:0]           j_q;
  logic signed [SW-1:0]    acc_q [NUM_CLASSES];
  logic signed [SW-1:0]    best_q;
  logic [CW-1:0]           best_cls_q;

  logic                    clause;
  logic                    last_j;
  logic                    last_cls;
  logic                    cfg_hit;
  logic signed [SW-1:0]    delta;
  logic signed [SW-1:0]    cls_sum_nxt;

  assign last_j   = (j_q == LAST_J);
  assign last_cls = (cls_q == LAST_CLS);
  assign cfg_hit  = (state == ST_IDLE) && cfg_we && ({1'b0, cfg_addr} < TOTAL_L);

  tm_clause_eval #(
    .NUM_FEATURES     (NUM_FEATURES),
    .EMPTY_CLAUSE_OUT (EMPTY_CLAUSE_OUT)
  ) u_eval (
    .features (feat_q),
    .exclude  (masks[idx_q]),
    .clause   (clause)
  );

  // Even clauses vote for the class, odd clauses vote against it.
  always_comb begin
    delta = '0;
    if (clause) begin
      if (j_q[0]) delta = '1;
      else        delta = SW'(1);
    end
    cls_sum_nxt = acc_q[cls_q] + delta;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_EVAL;
      ST_EVAL: if (last_j && last_cls) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    dbg_state = state;
  end

  // Mask writes share the accept edge, so an accepted sample already sees a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TOTAL; i++) masks[i] <= '1;
      for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
      feat_q     <= '0;
      idx_q      <= '0;
      cls_q      <= '0;
      j_q        <= '0;
      best_q     <= '0;
      best_cls_q <= '0;
    end else begin
      if (cfg_hit) masks[cfg_addr] <= cfg_data;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            feat_q <= features;
            for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
            idx_q      <= '0;
            cls_q      <= '0;
            j_q        <= '0;
            best_q     <= '0;
            best_cls_q <= '0;
          end
        end
        ST_EVAL: begin
          acc_q[cls_q] <= cls_sum_nxt;
          idx_q        <= idx_q + 1'b1;
          if (last_j) begin
            j_q   <= '0;
            cls_q <= last_cls ? '0 : cls_q + 1'b1;
            // Strict greater-than keeps the lower index on ties.
            if ((cls_q == '0) || (cls_sum_nxt > best_q)) begin
              best_q     <= cls_sum_nxt;
              best_cls_q <= cls_q;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) class_sums[c*SW +: SW] = acc_q[c];
    pred_class = best_cls_q;
  end

endmodule
